q5a_serial_negate_rx: RTL and testbench

Serial two's-complement receiver: takes the LSB-first negated bit stream produced by the serial two's-complement converter and re-negates it on the fly. It reassembles each WIDTH-bit frame into a parallel word and presents it on a valid/ready output. It sits on the far end of the serial link, feeding the parallel datapath.

---
 rtl/q5a_serial_negate_rx_if.sv | 25 ++
 rtl/q5a_serial_negate_rx.sv | 143 ++++++++++++++
 tb/tb_q5a_serial_negate_rx.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/q5a_serial_negate_rx_if.sv
// q5a_serial_negate_rx_if: serial-in / parallel-out bundle for the serial
// two's-complement receiver. The slave modport is the receiver; the master
// modport is its environment, which drives the serial link and consumes words.
interface q5a_serial_negate_rx_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             x;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             overflow;
  logic             perr;
  logic             busy;

  modport slave (
    input  start, x, out_ready,
    output out_data, out_valid, overflow, perr, busy
  );

  modport master (
    output start, x, out_ready,
    input  out_data, out_valid, overflow, perr, busy
  );
endinterface

// File: rtl/q5a_serial_negate_rx.sv
// q5a_serial_negate_rx: receives an LSB-first, two's-complement-negated bit
// stream, negates it back on the fly (copy bits up to and including the first
// 1, invert the rest) and presents each WIDTH-bit frame on a valid/ready port.
// The shift register and the output register are separate, so a new frame can
// be received while the previous word is still held.
// Optional feature: define Q5A_RX_PARITY_EN to add a trailing even-parity bit
// per frame (computed over the encoded bits) and report mismatches on perr.
module q5a_serial_negate_rx #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   aresetn,
  q5a_serial_negate_rx_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] C_LAST_DATA = CW'(WIDTH - 1);
`ifdef Q5A_RX_PARITY_EN
  localparam logic [CW-1:0] C_PAR_BIT   = CW'(WIDTH);
`endif

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_sreg, w_sreg_next;
  logic             r_seen_one, w_seen_next;
  logic             r_par, w_par_next;
  logic [CW-1:0]    r_count, w_count_next;

  logic             w_r;
  logic             w_complete;
  logic [WIDTH-1:0] w_word;
  logic             w_perr;

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_overflow;
  logic             r_perr;

  // Re-negated bit: pass bits through until the first 1 has gone by, then invert.
  assign w_r = r_seen_one ? ~bus.x : bus.x;

  // Next-state and frame-assembly decode.
  always_comb begin
    // NOTE: every signal gets a default first so no path can leave it unassigned (no latch).
    w_state_next = r_state;
    w_sreg_next  = r_sreg;
    w_seen_next  = r_seen_one;
    w_par_next   = r_par;
    w_count_next = r_count;
    w_complete   = 1'b0;
    w_word       = r_sreg;
    w_perr       = 1'b0;

    if (bus.start) begin
      // Bit 0 of a frame: seen_one starts clear, so the bit passes unchanged.
      // In SHIFT this abandons the partial frame and restarts it.
      w_sreg_next  = {bus.x, r_sreg[WIDTH-1:1]};
      w_seen_next  = bus.x;
      w_par_next   = bus.x;
      w_count_next = CW'(1);
      w_state_next = S_SHIFT;
    end else if (r_state == S_SHIFT) begin
`ifdef Q5A_RX_PARITY_EN
      if (r_count == C_PAR_BIT) begin
        // Parity bit: checked only, never shifted in and never touches seen_one.
        w_complete   = 1'b1;
        w_word       = r_sreg;
        w_perr       = r_par ^ bus.x;
        w_count_next = '0;
        w_state_next = S_IDLE;
      end else begin
        w_sreg_next  = {w_r, r_sreg[WIDTH-1:1]};
        w_seen_next  = r_seen_one | bus.x;
        w_par_next   = r_par ^ bus.x;
        w_count_next = r_count + CW'(1);
      end
`else
      w_sreg_next  = {w_r, r_sreg[WIDTH-1:1]};
      w_seen_next  = r_seen_one | bus.x;
      w_par_next   = r_par ^ bus.x;
      w_count_next = r_count + CW'(1);
      if (r_count == C_LAST_DATA) begin
        w_complete   = 1'b1;
        w_word       = w_sreg_next;
        w_count_next = '0;
        w_state_next = S_IDLE;
      end
`endif
    end
  end

  // Receive-side state: FSM state, shift register, running flags and bit count.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= S_IDLE;
      r_sreg     <= '0;
      r_seen_one <= 1'b0;
      r_par      <= 1'b0;
      r_count    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state    <= w_state_next;
      r_sreg     <= w_sreg_next;
      r_seen_one <= w_seen_next;
      r_par      <= w_par_next;
      r_count    <= w_count_next;
    end
  end

  // Output holding register: load on completion if free or being drained, else drop and flag.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_perr      <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      if (w_complete) begin
        if (!r_out_valid || bus.out_ready) begin
          r_out_data  <= w_word;
          r_perr      <= w_perr;
          r_out_valid <= 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.overflow  = r_overflow;
  assign bus.perr      = r_perr;
  assign bus.busy      = (r_state == S_SHIFT);

endmodule

// File: tb/tb_q5a_serial_negate_rx.sv
// tb_q5a_serial_negate_rx: directed bench for q5a_serial_negate_rx (WIDTH=8).
// Inputs change on the falling edge; outputs are compared on the falling edge,
// half a cycle after the rising edge that updated them.
module tb_q5a_serial_negate_rx;

  localparam int W = 8;
`ifdef Q5A_RX_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic clk = 1'b0;
  logic aresetn = 1'b0;

  q5a_serial_negate_rx_if #(.WIDTH(W)) bus ();

  q5a_serial_negate_rx #(.WIDTH(W)) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0] enc;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one full frame LSB first; optionally raise out_ready with the last bit.
  task automatic send_frame(input logic [W-1:0] w, input logic pbit, input bit ready_last);
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      bus.start = (i == 0);
      bus.x     = (i < W) ? w[i] : pbit;
      if (ready_last && i == FL - 1) bus.out_ready = 1'b1;
    end
  endtask

  task automatic step_idle();
    @(negedge clk);
    bus.start = 1'b0;
    bus.x     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] tmp;

    vecs[0] = '{enc: 8'hFB, exp: 8'h05};
    vecs[1] = '{enc: 8'h00, exp: 8'h00};
    vecs[2] = '{enc: 8'h80, exp: 8'h80};
    vecs[3] = '{enc: 8'h01, exp: 8'hFF};
    vecs[4] = '{enc: 8'hFF, exp: 8'h01};
    vecs[5] = '{enc: 8'h7F, exp: 8'h81};
    vecs[6] = '{enc: 8'h55, exp: 8'hAB};
    vecs[7] = '{enc: 8'h02, exp: 8'hFE};

    bus.start     = 1'b0;
    bus.x         = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state.
    #2;
    check("rst out_data", 32'(bus.out_data), 32'h00);
    check("rst out_valid", 32'(bus.out_valid), 0);
    check("rst overflow", 32'(bus.overflow), 0);
    check("rst perr", 32'(bus.perr), 0);
    check("rst busy", 32'(bus.busy), 0);
    @(negedge clk);
    aresetn = 1'b1;
    step_idle();

    // Table: one frame each, consumer always ready.
    bus.out_ready = 1'b1;
    foreach (vecs[k]) begin
      send_frame(vecs[k].enc, ^vecs[k].enc, 1'b0);
      step_idle();
      check($sformatf("vec%0d valid", k), 32'(bus.out_valid), 1);
      check($sformatf("vec%0d data", k), 32'(bus.out_data), 32'(vecs[k].exp));
      check($sformatf("vec%0d perr", k), 32'(bus.perr), 0);
      check($sformatf("vec%0d overflow", k), 32'(bus.overflow), 0);
      step_idle();
      check($sformatf("vec%0d valid drop", k), 32'(bus.out_valid), 0);
    end

    // Back-to-back frames with consumer stalled: second word dropped.
    bus.out_ready = 1'b0;
    send_frame(8'hFB, 1'b1, 1'b0);
    send_frame(8'h01, 1'b1, 1'b0);
    step_idle();
    check("b2b held valid", 32'(bus.out_valid), 1);
    check("b2b held data", 32'(bus.out_data), 32'h05);
    check("b2b overflow pulse", 32'(bus.overflow), 1);
    bus.out_ready = 1'b1;
    step_idle();
    check("b2b overflow cleared", 32'(bus.overflow), 0);
    check("b2b valid drop", 32'(bus.out_valid), 0);
    check("b2b data retained", 32'(bus.out_data), 32'h05);

    // Completion on the same edge that drains the held word.
    bus.out_ready = 1'b0;
    send_frame(8'hFB, 1'b1, 1'b0);
    step_idle();
    check("sim first valid", 32'(bus.out_valid), 1);
    check("sim first data", 32'(bus.out_data), 32'h05);
    send_frame(8'h01, 1'b1, 1'b1);
    step_idle();
    bus.out_ready = 1'b0;
    check("sim valid kept", 32'(bus.out_valid), 1);
    check("sim new data", 32'(bus.out_data), 32'hFF);
    check("sim no overflow", 32'(bus.overflow), 0);

    // Reset in the middle of a frame, with a word held.
    tmp = 8'hFB;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.start = (i == 0);
      bus.x     = tmp[i];
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("midrst busy before", 32'(bus.busy), 1);
    aresetn = 1'b0;
    #1;
    check("midrst busy", 32'(bus.busy), 0);
    check("midrst valid", 32'(bus.out_valid), 0);
    check("midrst data", 32'(bus.out_data), 32'h00);
    @(negedge clk);
    aresetn = 1'b1;
    bus.out_ready = 1'b1;
    send_frame(8'hFB, 1'b1, 1'b0);
    step_idle();
    check("postrst valid", 32'(bus.out_valid), 1);
    check("postrst data", 32'(bus.out_data), 32'h05);
    step_idle();
    check("postrst single word", 32'(bus.out_valid), 0);

    // start reasserted mid-frame: partial frame discarded.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.start = (i == 0);
      bus.x     = 1'b1;
    end
    send_frame(8'hFB, 1'b1, 1'b0);
    check("restart no early word", 32'(bus.out_valid), 0);
    step_idle();
    check("restart valid", 32'(bus.out_valid), 1);
    check("restart data", 32'(bus.out_data), 32'h05);
    step_idle();

`ifdef Q5A_RX_PARITY_EN
    // Parity: 0xFB has seven ones, so the correct even-parity bit is 1.
    send_frame(8'hFB, 1'b1, 1'b0);
    step_idle();
    check("par good data", 32'(bus.out_data), 32'h05);
    check("par good perr", 32'(bus.perr), 0);
    step_idle();
    send_frame(8'hFB, 1'b0, 1'b0);
    step_idle();
    check("par bad valid", 32'(bus.out_valid), 1);
    check("par bad data", 32'(bus.out_data), 32'h05);
    check("par bad perr", 32'(bus.perr), 1);
    step_idle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
